// File: rtl/spi_ram_bridge.sv
// SPI mode-0 slave that bridges a host to a single-port RAM: the host writes
// or reads bursts of 32-bit words through a CMD/ADDR/DATA frame.
module spi_ram_bridge #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0]      BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0]      WORD_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [7:0]            CMD_WRITE = 8'h02;
  localparam logic [7:0]            CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WR_DATA,
    S_WR_COMMIT,
    S_RD_FETCH,
    S_RD_DATA,
    S_DISCARD
  } state_t;

  // Synchronizers and edge history. cs_prev resets low so a frame already in
  // progress at reset release never looks like a fresh CS falling edge.
  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      cs_meta   <= 1'b0;
      cs_sync   <= 1'b0;
      cs_prev   <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= spi_sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= spi_cs_n;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      mosi_meta <= spi_mosi;
      mosi_sync <= mosi_meta;
    end
  end

  logic rise_c, fall_c, cs_fall_c;
  assign rise_c    = sclk_sync & ~sclk_prev;
  assign fall_c    = ~sclk_sync & sclk_prev;
  assign cs_fall_c = cs_prev & ~cs_sync;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-2:0]   rx_sr, rx_n;
  logic [DATA_WIDTH-2:0]   tx_sr, tx_n;
  logic                    is_read, is_read_n;
  logic                    rose, rose_n;
  logic                    miso_n, en_n, we_n, busy_n, err_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   wdata_n;
  logic [DATA_WIDTH-1:0]   rx_next_c;
  logic [ADDR_WIDTH-1:0]   addr_inc_c;

  // rx_sr keeps only the older bits; the newest bit comes straight from mosi.
  assign rx_next_c  = {rx_sr, mosi_sync};
  assign addr_inc_c = (ram_addr == ADDR_LAST) ? '0 : ram_addr + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      is_read   <= 1'b0;
      rose      <= 1'b0;
      spi_miso  <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      rx_sr     <= rx_n;
      tx_sr     <= tx_n;
      is_read   <= is_read_n;
      rose      <= rose_n;
      spi_miso  <= miso_n;
      ram_en    <= en_n;
      ram_we    <= we_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
      busy      <= busy_n;
      cmd_err   <= err_n;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rx_n      = rx_sr;
    tx_n      = tx_sr;
    is_read_n = is_read;
    rose_n    = rose;
    miso_n    = spi_miso;
    en_n      = 1'b0;
    we_n      = 1'b0;
    addr_n    = ram_addr;
    wdata_n   = ram_wdata;
    busy_n    = busy;
    err_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (cs_fall_c) begin
          state_n   = S_CMD;
          busy_n    = 1'b1;
          bit_cnt_n = '0;
          rx_n      = '0;
          rose_n    = 1'b0;
        end
      end

      S_CMD: begin
        if (rise_c) begin
          rx_n      = rx_next_c[DATA_WIDTH-2:0];
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt == BYTE_LAST) begin
            bit_cnt_n = '0;
            if (rx_next_c[7:0] == CMD_WRITE) begin
              is_read_n = 1'b0;
              state_n   = S_ADDR;
            end else if (rx_next_c[7:0] == CMD_READ) begin
              is_read_n = 1'b1;
              state_n   = S_ADDR;
            end else begin
              state_n = S_DISCARD;
              err_n   = 1'b1;
            end
          end
        end
      end

      S_ADDR: begin
        if (rise_c) begin
          rx_n      = rx_next_c[DATA_WIDTH-2:0];
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt == BYTE_LAST) begin
            bit_cnt_n = '0;
            addr_n    = rx_next_c[ADDR_WIDTH-1:0];
            if (is_read) begin
              state_n = S_RD_FETCH;
              en_n    = 1'b1;
            end else begin
              state_n = S_WR_DATA;
            end
          end
        end
      end

      S_WR_DATA: begin
        if (rise_c) begin
          rx_n      = rx_next_c[DATA_WIDTH-2:0];
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt == WORD_LAST) begin
            bit_cnt_n = '0;
            wdata_n   = rx_next_c;
            en_n      = 1'b1;
            we_n      = 1'b1;
            state_n   = S_WR_COMMIT;
          end
        end
      end

      S_WR_COMMIT: begin
        addr_n  = addr_inc_c;
        state_n = S_WR_DATA;
      end

      // ram_en is high this clk; the word's MSB goes straight to miso.
      S_RD_FETCH: begin
        tx_n    = ram_rdata[DATA_WIDTH-2:0];
        miso_n  = ram_rdata[DATA_WIDTH-1];
        rose_n  = 1'b0;
        state_n = S_RD_DATA;
      end

      S_RD_DATA: begin
        if (rise_c) begin
          rose_n    = 1'b1;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt == WORD_LAST) begin
            bit_cnt_n = '0;
            rose_n    = 1'b0;
            addr_n    = addr_inc_c;
            en_n      = 1'b1;
            state_n   = S_RD_FETCH;
          end
        end else if (fall_c && rose) begin
          miso_n = tx_sr[DATA_WIDTH-2];
          tx_n   = {tx_sr[DATA_WIDTH-3:0], 1'b0};
          rose_n = 1'b0;
        end
      end

      S_DISCARD: begin
        state_n = S_DISCARD;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // CS release aborts any frame; a partial write word is dropped.
    if (state != S_IDLE && cs_sync) begin
      state_n   = S_IDLE;
      busy_n    = 1'b0;
      miso_n    = 1'b0;
      en_n      = 1'b0;
      we_n      = 1'b0;
      err_n     = 1'b0;
      bit_cnt_n = '0;
      rose_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Bench for spi_ram_bridge: a host-side SPI driver feeds directed frames while
// monitors score RAM-port accesses and MISO words against queued expectations.
module tb_spi_ram_bridge;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        busy, cmd_err;

  always #5 clk = ~clk;

  spi_ram_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  // RAM model with a side door so the bench can preload words.
  logic [31:0] mem [256] = '{default: 32'h0};
  logic        pre_en   = 1'b0;
  logic [7:0]  pre_addr = 8'h0;
  logic [31:0] pre_data = 32'h0;

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  acc_t        acc_q[$];
  logic [31:0] rd_q[$];
  int          err_cnt    = 0;
  logic        prev_en    = 1'b0;
  logic        miso_watch = 1'b0;
  logic        miso_hi    = 1'b0;
  logic        rd_phase   = 1'b0;
  int          rd_bits    = 0;
  logic [31:0] rd_sr      = 32'h0;

  // RAM-port monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    acc_t e;
    if (!rst) begin
      if (ram_en) begin
        check("ram_en_single_clk", 32'(prev_en), 32'h0);
        if (acc_q.size() == 0) begin
          check("ram_access_unexpected", {23'h0, ram_we, ram_addr}, 32'hFFFF_FFFF);
        end else begin
          e = acc_q.pop_front();
          check("ram_we", 32'(ram_we), 32'(e.we));
          check("ram_addr", 32'(ram_addr), 32'(e.addr));
          if (e.we) check("ram_wdata", ram_wdata, e.data);
        end
      end else if (ram_we) begin
        check("ram_we_without_en", 32'(ram_we), 32'h0);
      end
      if (cmd_err) err_cnt++;
      if (miso_watch && spi_miso) miso_hi = 1'b1;
    end
    prev_en = ram_en;
  end

  // MISO monitor: assembles words on host sampling edges during read data.
  always @(posedge spi_sclk) begin
    if (rd_phase) begin
      rd_sr = {rd_sr[30:0], spi_miso};
      rd_bits++;
      if (rd_bits % 32 == 0) begin
        if (rd_q.size() == 0) check("miso_word_unexpected", rd_sr, ~rd_sr);
        else check("miso_word", rd_sr, rd_q.pop_front());
      end
    end
  end

  // Host-side SPI mode 0 driver; SCLK period is 16 clk.
  task automatic half_bit();
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    half_bit();
    spi_sclk = 1'b1;
    half_bit();
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic spi_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) spi_bit(w[i]);
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    half_bit();
  endtask

  task automatic cs_end();
    half_bit();
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic push_acc(input logic we, input logic [7:0] a, input logic [31:0] d);
    acc_t e;
    e.we   = we;
    e.addr = a;
    e.data = d;
    acc_q.push_back(e);
  endtask

  initial begin
    int          err_base;
    logic [19:0] partial;

    // Reset with random SPI pins
    rst      = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (2) begin
      @(negedge clk);
      spi_sclk = 1'($urandom_range(0, 1));
      spi_cs_n = 1'($urandom_range(0, 1));
      spi_mosi = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cmd_err", 32'(cmd_err), 32'h0);
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    rst      = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);

    // Single write to address 0x05
    push_acc(1'b1, 8'h05, 32'h1234_5678);
    cs_start();
    spi_byte(8'h02);
    check("busy_in_frame", 32'(busy), 32'h1);
    spi_byte(8'h05);
    spi_word(32'h1234_5678);
    cs_end();
    check("single_pending", 32'(acc_q.size()), 32'h0);
    check("single_mem5", mem[5], 32'h1234_5678);
    check("busy_after_frame", 32'(busy), 32'h0);

    // Burst write wrapping from 0xFF to 0x00
    push_acc(1'b1, 8'hFF, 32'hAAAA_0001);
    push_acc(1'b1, 8'h00, 32'hBBBB_0002);
    cs_start();
    spi_byte(8'h02);
    spi_byte(8'hFF);
    spi_word(32'hAAAA_0001);
    spi_word(32'hBBBB_0002);
    cs_end();
    check("wrap_pending", 32'(acc_q.size()), 32'h0);
    check("wrap_memFF", mem[255], 32'hAAAA_0001);
    check("wrap_mem00", mem[0], 32'hBBBB_0002);

    // Burst read of two words plus the trailing prefetch
    preload(8'h00, 32'h0122_0000);
    preload(8'h01, 32'h1312_0000);
    push_acc(1'b0, 8'h00, 32'h0);
    push_acc(1'b0, 8'h01, 32'h0);
    push_acc(1'b0, 8'h02, 32'h0);
    rd_q.push_back(32'h0122_0000);
    rd_q.push_back(32'h1312_0000);
    cs_start();
    spi_byte(8'h03);
    spi_byte(8'h00);
    rd_bits  = 0;
    rd_phase = 1'b1;
    spi_word(32'h0);
    spi_word(32'h0);
    rd_phase = 1'b0;
    cs_end();
    check("read_acc_pending", 32'(acc_q.size()), 32'h0);
    check("read_word_pending", 32'(rd_q.size()), 32'h0);
    check("read_bits", 32'(rd_bits), 32'd64);
    check("read_miso_idle", 32'(spi_miso), 32'h0);

    // Unknown command
    err_base   = err_cnt;
    miso_hi    = 1'b0;
    miso_watch = 1'b1;
    cs_start();
    spi_byte(8'h7F);
    spi_byte(8'h10);
    spi_word(32'hFFFF_FFFF);
    cs_end();
    miso_watch = 1'b0;
    check("bad_cmd_err_pulses", 32'(err_cnt - err_base), 32'd1);
    check("bad_cmd_miso", 32'(miso_hi), 32'h0);
    check("bad_cmd_mem10", mem[8'h10], 32'h0);

    // CS abort mid-word, then a good frame
    partial = 20'hABCDE;
    cs_start();
    spi_byte(8'h02);
    spi_byte(8'h20);
    for (int i = 19; i >= 0; i--) spi_bit(partial[i]);
    cs_end();
    check("abort_mem20", mem[8'h20], 32'h0);
    push_acc(1'b1, 8'h21, 32'hDEAD_BEEF);
    cs_start();
    spi_byte(8'h02);
    spi_byte(8'h21);
    spi_word(32'hDEAD_BEEF);
    cs_end();
    check("after_abort_pending", 32'(acc_q.size()), 32'h0);
    check("after_abort_mem21", mem[8'h21], 32'hDEAD_BEEF);
    check("total_err_pulses", 32'(err_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
